kernel_out_serializer: RTL
==========================

// Module: kernel_out_serializer
// PURPOSE
//  Sits inside the board wrapper, directly downstream of the HLS kernel's two ap_fifo output streams (C_out_0, C_out_1).
//  Buffers each stream and round-robin arbitrates between them.
//  Emits every accepted word on a 4-bit pin bus as one tag nibble followed by the data nibbles.
//  Keeps all kernel outputs observable, so synthesis cannot prune them.
//  Drives probe_out, a running parity of all emitted nibbles.
// PARAMETERS
//  DW     32  width of C_out_x_din; must be a multiple of 4
//  DEPTH  4   words per channel FIFO; must be a power of 2 and >= 2
// PORTS
//  ap_clk          in   1   sole clock
//  ap_rst          in   1   asynchronous, active-high reset
//  C_out_0_din     in   DW  channel-0 data
//  C_out_0_write   in   1   channel-0 write strobe
//  C_out_0_full_n  out  1   channel-0 space available
//  C_out_1_din     in   DW  channel-1 data
//  C_out_1_write   in   1   channel-1 write strobe
//  C_out_1_full_n  out  1   channel-1 space available
//  data_out        out  4   emitted nibble
//  data_valid      out  1   data_out is valid this cycle
//  probe_out       out  1   XOR of every bit ever emitted since reset
// BEHAVIOUR
//  Reset: async assert, sync release; clears FIFOs, state, rr pointer and parity.
//   Output values during reset: data_out=0, data_valid=0, probe_out=0, C_out_x_full_n=1.
//  Write acceptance: a write is accepted iff write=1 and full_n=1 on the same posedge.
//   write while full_n=0: the word is dropped, nothing else changes.
//   full_n = (count != DEPTH), combinational from count.
//   A pop in the same cycle does not free space for that cycle's write.
//  Pop on full: space frees only on the next cycle.
//  Pop on empty: a same-cycle write into an empty FIFO cannot be popped until the next cycle (no fall-through).
//  FSM IDLE -> TAG -> DATA:
//   IDLE: if any FIFO is non-empty, grant it and pop one word into shift_q; go to TAG.
//    Both non-empty: grant the channel != last_grant (rr); last_grant is 0 after reset, so the first grant is channel 1.
//    Hmm-free rule: rr pointer updates on every grant.
//   TAG: data_valid=1, data_out = 4'hA for ch0, 4'h5 for ch1; go to DATA with nib_cnt=0.
//   DATA: data_valid=1, data_out = shift_q[3:0]; shift_q >>= 4; nib_cnt++.
//    When nib_cnt == DW/4-1 (last nibble), arbitrate exactly as in IDLE in the same cycle.
//    If a grant is made, go to TAG directly (back-to-back, no bubble); else go to IDLE.
//  Frame: 1+DW/4 cycles per word (9 for DW=32), data LSB-nibble first; data_valid is continuous across back-to-back frames.
//  Latency: a write into an empty, idle block gives the TAG nibble on cycle +2 after the write edge.
//   +1 IDLE sees non-empty/pops, +2 TAG.
//  Outputs: data_out and data_valid are registered (driven from state regs, not combinational from inputs).
//  probe_out: par_q ^= ^data_out on every cycle with data_valid=1; probe_out = par_q, registered.
//  Counters: FIFO pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  Reset mid-frame: the frame is aborted, no trailing nibbles are emitted, and buffered words are lost.
// STRUCTURE
//  Shared package kernel_out_pkg: TAG_CH0=4'hA, TAG_CH1=4'h5, NIB_W=4, state enum {S_IDLE,S_TAG,S_DATA}.
//  Sub-module out_word_fifo (DW, DEPTH): sync FIFO with wr_en/rd_en/dout/empty/full/count; instantiated twice.
//  Top holds the arbiter, FSM, shifter and parity register.
// TESTING
//  1. Reset then single write ch0 32'h12345678 -> data_valid=1 for 9 cycles.
//     Nibble sequence: A,8,7,6,5,4,3,2,1; probe_out=1 afterwards (par of A..1 = 1).
//  2. Same-cycle writes ch0=32'h0, ch1=32'hFFFFFFFF -> ch1 frame (5,F x8) then ch0 frame (A,0 x8).
//     The two frames are back-to-back with 18 contiguous valid cycles.
//  3. Five back-to-back writes to ch0 with DEPTH=4, none popped yet:
//     full_n drops after the 4th accepted word; the 5th write is dropped; exactly 4 frames are emitted.
//  4. Continuous writes on both channels -> tags strictly alternate 5,A,5,A...; no bubbles; full_n re-asserts the cycle after each pop.
//  5. Assert ap_rst mid-DATA (nibble 3) -> data_valid, data_out, probe_out = 0 immediately (async).
//     After release the block stays IDLE with both full_n=1.
//  6. Scoreboard: random writes/backpressure for 10k words, then reassemble frames.
//     Per-channel order is preserved; every accepted word is reassembled exactly once; probe_out matches the model parity.

Source files
------------

// File: rtl/kernel_out_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kernel_out_pkg
// Purpose : Shared tags, nibble width and FSM state type for the serializer.
// Revision: 1.0
// ============================================================================
package kernel_out_pkg;

    localparam int         NIB_W   = 4;
    localparam logic [3:0] TAG_CH0 = 4'hA;
    localparam logic [3:0] TAG_CH1 = 4'h5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    function automatic logic [3:0] tag_of(input logic ch);
        return ch ? TAG_CH1 : TAG_CH0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_word_fifo.sv
`default_nettype none
// ============================================================================
// Module  : out_word_fifo
// Purpose : Small synchronous FIFO; no fall-through, full/empty from count.
// Revision: 1.0
// ============================================================================
module out_word_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DW-1:0]              din,
    input  logic                       rd_en,
    output logic [DW-1:0]              dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem[rd_ptr];

    // Both strobes qualify on the registered count, so a pop never frees
    // room for a write in the same cycle and a fresh word is not poppable.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/kernel_out_serializer.sv
`default_nettype none
// ============================================================================
// Module  : kernel_out_serializer
// Purpose : Buffers two kernel output streams, round-robin arbitrates, and
//           emits each word as a tag nibble plus LSB-first data nibbles.
// Revision: 1.0
// ============================================================================
module kernel_out_serializer
    import kernel_out_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic [DW-1:0] C_out_0_din,
    input  logic          C_out_0_write,
    output logic          C_out_0_full_n,
    input  logic [DW-1:0] C_out_1_din,
    input  logic          C_out_1_write,
    output logic          C_out_1_full_n,
    output logic [3:0]    data_out,
    output logic          data_valid,
    output logic          probe_out
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NIBS  = DW / NIB_W;
    localparam int NCW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [NCW-1:0] LAST_NIB = NCW'(NIBS - 1);

    logic [DW-1:0]  dout0, dout1;
    logic           empty0, empty1, full0, full1;
    logic [CW-1:0]  count0, count1;
    logic           pop0, pop1;

    state_t         state, next_state;
    logic [DW-1:0]  shift_q;
    logic [NCW-1:0] nib_cnt;
    logic           cur_ch;
    logic           last_grant;
    logic [3:0]     data_q;
    logic           valid_q;
    logic           par_q;

    logic           pick1, fire, arb_en;

    out_word_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .wr_en (C_out_0_write && !full0),
        .din   (C_out_0_din),
        .rd_en (pop0),
        .dout  (dout0),
        .empty (empty0),
        .full  (full0),
        .count (count0)
    );

    out_word_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .wr_en (C_out_1_write && !full1),
        .din   (C_out_1_din),
        .rd_en (pop1),
        .dout  (dout1),
        .empty (empty1),
        .full  (full1),
        .count (count1)
    );

    assign C_out_0_full_n = (count0 != CW'(DEPTH));
    assign C_out_1_full_n = (count1 != CW'(DEPTH));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= next_state;
    end

    // Arbitration happens in IDLE and on the last data nibble, which lets
    // consecutive frames abut with no gap on data_valid.
    always_comb begin
        next_state = state;
        arb_en     = 1'b0;
        pick1      = !empty1 && (empty0 || !last_grant);
        case (state)
            S_IDLE: arb_en = 1'b1;
            S_TAG:  next_state = S_DATA;
            S_DATA: begin
                if (nib_cnt == LAST_NIB) begin
                    arb_en     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
        fire = arb_en && (!empty0 || !empty1);
        if (fire) next_state = S_TAG;
        pop1 = fire && pick1;
        pop0 = fire && !pick1;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            shift_q    <= '0;
            nib_cnt    <= '0;
            cur_ch     <= 1'b0;
            last_grant <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            if (fire) begin
                shift_q    <= pick1 ? dout1 : dout0;
                cur_ch     <= pick1;
                last_grant <= pick1;
            end else if (state == S_DATA) begin
                shift_q <= shift_q >> NIB_W;
            end

            if (state == S_TAG)       nib_cnt <= '0;
            else if (state == S_DATA) nib_cnt <= nib_cnt + 1'b1;

            valid_q <= (state == S_TAG) || (state == S_DATA);
            case (state)
                S_TAG:   data_q <= tag_of(cur_ch);
                S_DATA:  data_q <= shift_q[NIB_W-1:0];
                default: data_q <= '0;
            endcase

            if (valid_q) par_q <= par_q ^ (^data_q);
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign probe_out  = par_q;

endmodule
`default_nettype wire
